// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Owner encoding, requester indices and lock counter sizing live here.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam int REQ_CPU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int LOCK_CNT_W = 4;

  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

  // Owner state corresponding to a requester index.
  function automatic owner_e owner_of(input logic idx);
    return idx ? OWN_1 : OWN_0;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way grant selector: single requester wins outright,
// a tie goes to the locked owner while under budget, else round-robin.
module rr_pick2
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic [1:0] i_req,
  input  owner_e     i_owner,
  input  lock_cnt_t  i_lock_cnt,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

  localparam lock_cnt_t LOCK_MAX = lock_cnt_t'(MAX_LOCK);

  logic w_under_budget;

  assign w_under_budget = (i_lock_cnt < LOCK_MAX);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (i_owner == OWN_0 && w_under_budget) begin
          o_gnt = 2'b01;
        end else if (i_owner == OWN_1 && w_under_budget) begin
          o_gnt = 2'b10;
        end else if (i_last_gnt) begin
          o_gnt = 2'b01;
        end else begin
          o_gnt = 2'b10;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (m0) and the loader (m1).
// Grants are combinational; read data returns one cycle later tagged with rvalid.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int MAX_LOCK       = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      m0_req,
  input  logic                      m0_rnw,
  input  logic [MEM_ADDR_WIDTH-1:0] m0_addr,
  input  logic [MEM_DATA_WIDTH-1:0] m0_wdata,
  input  logic                      m0_lock,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_rnw,
  input  logic [MEM_ADDR_WIDTH-1:0] m1_addr,
  input  logic [MEM_DATA_WIDTH-1:0] m1_wdata,
  input  logic                      m1_lock,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] m1_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] ram_address,
  output logic [MEM_DATA_WIDTH-1:0] ram_data_in,
  output logic                      ram_rnw,
  input  logic [MEM_DATA_WIDTH-1:0] ram_data_out
);

  localparam lock_cnt_t LOCK_MAX = lock_cnt_t'(MAX_LOCK);

  owner_e    r_owner;
  lock_cnt_t r_lock_cnt;
  logic      r_last_gnt;
  logic [1:0] r_rvalid;

  owner_e    w_owner_next;
  lock_cnt_t w_lock_cnt_next;
  logic      w_last_gnt_next;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic [1:0] w_rnw;
  logic       w_gnt_any;
  logic       w_gnt_idx;
  logic       w_gnt_lock;

  assign w_req      = {m1_req, m0_req};
  assign w_rnw      = {m1_rnw, m0_rnw};
  assign w_gnt_any  = |w_gnt;
  assign w_gnt_idx  = w_gnt[REQ_LOAD];
  assign w_gnt_lock = w_gnt_idx ? m1_lock : m0_lock;

  rr_pick2 #(
    .MAX_LOCK (MAX_LOCK)
  ) u_pick (
    .i_req      (w_req),
    .i_owner    (r_owner),
    .i_lock_cnt (r_lock_cnt),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt)
  );

  assign m0_gnt = w_gnt[REQ_CPU];
  assign m1_gnt = w_gnt[REQ_LOAD];

  // Owner FSM: state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= OWN_NONE;
      r_lock_cnt <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      r_owner    <= w_owner_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_last_gnt <= w_last_gnt_next;
    end
  end

  // Owner FSM: next state. Ownership only ever passes through OWN_NONE.
  always_comb begin
    w_owner_next    = r_owner;
    w_lock_cnt_next = r_lock_cnt;
    w_last_gnt_next = r_last_gnt;
    if (w_gnt_any) begin
      w_last_gnt_next = w_gnt_idx;
      if (w_gnt_lock && r_owner == owner_of(w_gnt_idx)) begin
        if (r_lock_cnt < LOCK_MAX) begin
          w_lock_cnt_next = r_lock_cnt + lock_cnt_t'(1);
        end
      end else if (w_gnt_lock && r_owner == OWN_NONE) begin
        w_owner_next    = owner_of(w_gnt_idx);
        w_lock_cnt_next = lock_cnt_t'(1);
      end else begin
        w_owner_next    = OWN_NONE;
        w_lock_cnt_next = '0;
      end
    end
  end

  // Owner FSM: outputs. Idle cycles park the RAM on a harmless read of 0.
  always_comb begin
    ram_address = '0;
    ram_data_in = '0;
    ram_rnw     = 1'b1;
    if (w_gnt_any) begin
      ram_address = w_gnt_idx ? m1_addr  : m0_addr;
      ram_data_in = w_gnt_idx ? m1_wdata : m0_wdata;
      ram_rnw     = w_gnt_idx ? m1_rnw   : m0_rnw;
    end
  end

  // One-cycle read-latency tag per requester, matching the RAM's registered output.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_rvalid[gi] <= 1'b0;
        end else begin
          r_rvalid[gi] <= w_gnt[gi] & w_rnw[gi];
        end
      end
    end
  endgenerate

  assign m0_rvalid = r_rvalid[REQ_CPU];
  assign m1_rvalid = r_rvalid[REQ_LOAD];
  assign m0_rdata  = ram_data_out;
  assign m1_rdata  = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a rule-level
// arbitration/memory model checked every cycle, plus literal expectations.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_rnw, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_rnw, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_rnw;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ram_arbiter #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (DW),
    .MAX_LOCK       (ML)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .m0_req       (m0_req),
    .m0_rnw       (m0_rnw),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_lock      (m0_lock),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_rnw       (m1_rnw),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_lock      (m1_lock),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_rnw      (ram_rnw),
    .ram_data_out (ram_data_out)
  );

  // Single-port RAM with registered read output.
  logic [DW-1:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
  end
  always @(posedge clock) begin
    if (!ram_rnw) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  // Rule-level model: owner (-1 none, else index), lock count, last grant, pending reads.
  int            mdl_own;
  int            mdl_cnt;
  int            mdl_last;
  bit            mdl_pend [2];
  logic [DW-1:0] mdl_pend_data;
  bit            mdl_written [256];
  logic [DW-1:0] mdl_shadow  [256];

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
    return mdl_written[a] ? mdl_shadow[a] : (a ^ 8'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_own     = -1;
    mdl_cnt     = 0;
    mdl_last    = 1;
    mdl_pend[0] = 1'b0;
    mdl_pend[1] = 1'b0;
  endtask

  task automatic model_check();
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er;
    logic          lk;
    if (!reset_n) begin
      check("rst_rvalid0", m0_rvalid, 0);
      check("rst_rvalid1", m1_rvalid, 0);
      model_reset();
      return;
    end
    g = -1;
    if (m0_req && !m1_req) g = 0;
    else if (m1_req && !m0_req) g = 1;
    else if (m0_req && m1_req) g = (mdl_own >= 0 && mdl_cnt < ML) ? mdl_own : 1 - mdl_last;
    ea = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : '0;
    ed = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
    er = (g == 0) ? m0_rnw   : (g == 1) ? m1_rnw   : 1'b1;
    check("m0_gnt", m0_gnt, 32'(g == 0));
    check("m1_gnt", m1_gnt, 32'(g == 1));
    check("ram_address", ram_address, ea);
    check("ram_data_in", ram_data_in, ed);
    check("ram_rnw", ram_rnw, er);
    check("m0_rvalid", m0_rvalid, mdl_pend[0]);
    check("m1_rvalid", m1_rvalid, mdl_pend[1]);
    if (mdl_pend[0]) check("m0_rdata", m0_rdata, mdl_pend_data);
    if (mdl_pend[1]) check("m1_rdata", m1_rdata, mdl_pend_data);
    mdl_pend[0] = (g == 0) && er;
    mdl_pend[1] = (g == 1) && er;
    if (g >= 0) begin
      if (er) mdl_pend_data = mdl_read(ea);
      else begin
        mdl_shadow[ea]  = ed;
        mdl_written[ea] = 1'b1;
      end
      lk = (g == 0) ? m0_lock : m1_lock;
      if (lk && mdl_own == g) mdl_cnt = (mdl_cnt < ML) ? mdl_cnt + 1 : ML;
      else if (lk && mdl_own < 0) begin
        mdl_own = g;
        mdl_cnt = 1;
      end else begin
        mdl_own = -1;
        mdl_cnt = 0;
      end
      mdl_last = g;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_check();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [5:0] seq6;
  logic [4:0] seq5;

  initial begin
    reset_n = 1'b0;
    {m0_req, m0_rnw, m0_lock, m1_req, m1_rnw, m1_lock} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    model_reset();

    sample(); tick();
    sample(); tick();
    reset_n = 1'b1;
    sample();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_ram_rnw", ram_rnw, 1);
    tick();

    // m0 write then read back
    m0_req = 1; m0_rnw = 0; m0_addr = 8'h10; m0_wdata = 8'hA5;
    sample();
    check("wr_m0_gnt", m0_gnt, 1);
    check("wr_ram_rnw", ram_rnw, 0);
    tick();
    m0_rnw = 1;
    sample();
    check("rd_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 0;
    sample();
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 8'hA5);
    check("rd_m1_rvalid", m1_rvalid, 0);
    tick();

    // unlocked tie: m0 was granted last, so m1 leads and they alternate
    m0_req = 1; m0_rnw = 1; m0_addr = 8'h10;
    m1_req = 1; m1_rnw = 1; m1_addr = 8'h11;
    seq6 = '0;
    for (int i = 0; i < 6; i++) begin
      sample(); seq6[i] = m0_gnt; tick();
    end
    check("rr_seq_m0", seq6, 6'b101010);

    // m1 locked burst: four grants, then m0 must get in
    m1_lock = 1;
    seq5 = '0;
    for (int i = 0; i < 5; i++) begin
      sample(); seq5[i] = m1_gnt; tick();
    end
    check("lock_seq_m1", seq5, 5'b01111);
    m0_req = 0; m1_req = 0; m1_lock = 0;

    // m1 write, m0 reads same address next cycle
    m1_req = 1; m1_rnw = 0; m1_addr = 8'h22; m1_wdata = 8'h3C;
    sample();
    check("wr2_m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 0; m0_req = 1; m0_rnw = 1; m0_addr = 8'h22;
    sample();
    check("rd2_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 0;
    sample();
    check("rd2_m0_rvalid", m0_rvalid, 1);
    check("rd2_m0_rdata", m0_rdata, 8'h3C);
    tick();

    // async reset right after a read grant swallows its rvalid
    m0_req = 1; m0_rnw = 1; m0_addr = 8'h22;
    sample();
    check("ar_m0_gnt", m0_gnt, 1);
    #1;
    reset_n = 1'b0; m0_req = 0;
    model_reset();
    tick();
    sample();
    check("ar_m0_rvalid", m0_rvalid, 0);
    tick();
    sample(); tick();
    reset_n = 1'b1;
    m0_req = 1; m0_addr = 8'h10; m1_req = 1; m1_rnw = 1; m1_addr = 8'h11;
    sample();
    check("ar_tie_m0", m0_gnt, 1);
    check("ar_tie_m1", m1_gnt, 0);
    tick();
    m0_req = 0;
    sample(); tick();
    m1_req = 0;
    sample(); tick();

    // idle bus
    for (int i = 0; i < 3; i++) begin
      sample();
      check("idle_rnw", ram_rnw, 1);
      check("idle_addr", ram_address, 0);
      check("idle_gnt", {m1_gnt, m0_gnt}, 0);
      check("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
      tick();
    end

    // readback after idle: contents untouched
    m1_req = 1; m1_rnw = 1; m1_addr = 8'h10;
    sample(); tick();
    m1_addr = 8'h00;
    sample();
    check("rb_m1_rdata10", m1_rdata, 8'hA5);
    tick();
    m1_req = 0;
    sample();
    check("rb_m1_rvalid", m1_rvalid, 1);
    check("rb_m1_rdata00", m1_rdata, 8'h5A);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
